// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame
// clocked out by the device, ACK sampling, and an overall transfer timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       done,
  output logic       ack_error,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

  state_t        state;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fe;
  logic [10:0]   frame;
  logic [3:0]    idx;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic          ack_bad;

  assign fe = clk_prev & ~clk_sync[1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state             <= IDLE;
      clk_sync          <= 2'b11;
      dat_sync          <= 2'b11;
      clk_prev          <= 1'b1;
      frame             <= '0;
      idx               <= '0;
      icnt              <= '0;
      tcnt              <= '0;
      ack_bad           <= 1'b0;
      tx_ready          <= 1'b1;
      ps2_clk_drive_low <= 1'b0;
      ps2_dat_drive_low <= 1'b0;
      done              <= 1'b0;
      ack_error         <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      dat_sync  <= {dat_sync[0], PS2_DAT};
      clk_prev  <= clk_sync[1];
      done      <= 1'b0;
      ack_error <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            // {stop, odd parity, data LSB-first, start}
            frame             <= {1'b1, ~^tx_data, tx_data, 1'b0};
            tx_ready          <= 1'b0;
            ps2_clk_drive_low <= 1'b1;
            icnt              <= '0;
            state             <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_dat_drive_low <= 1'b1;
            state             <= REQ;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        REQ: begin
          ps2_clk_drive_low <= 1'b0;
          idx               <= '0;
          tcnt              <= '0;
          state             <= SEND;
        end
        SEND, WAIT_IDLE: begin
          // Abort takes priority over any edge seen in the same cycle.
          if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            timeout           <= 1'b1;
            tx_ready          <= 1'b1;
            state             <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (state == SEND) begin
              if (fe) begin
                if (idx == 4'd10) begin
                  ack_bad           <= dat_sync[1];
                  ps2_dat_drive_low <= 1'b0;
                  state             <= WAIT_IDLE;
                end else begin
                  idx               <= idx + 4'd1;
                  ps2_dat_drive_low <= ~frame[idx + 4'd1];
                end
              end
            end else if (clk_sync[1] && dat_sync[1]) begin
              done      <= 1'b1;
              ack_error <= ack_bad;
              tx_ready  <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, expectation queue filled at
// issue time and drained by a monitor on every done/timeout pulse.
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, cdl, ddl, done, ack_error, timeout;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = dev_clk & ~cdl;
  assign ps2_dat_line = dev_dat & ~ddl;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .PS2_CLK(ps2_clk_line), .PS2_DAT(ps2_dat_line),
    .ps2_clk_drive_low(cdl), .ps2_dat_drive_low(ddl),
    .done(done), .ack_error(ack_error), .timeout(timeout));

  typedef struct {
    logic [7:0] data;
    logic       ack_err;
    logic       tmo;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0, n_err = 0;
  int         dev_mode = 0;  // 0 = ACK, 1 = no ACK, 2 = never clocks
  int         fe_count = 0;
  logic       dev_busy = 1'b0;
  logic [9:0] cap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line content after fe1..fe10: data LSB first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Device: waits for request-to-send, then generates 11 falling edges.
  initial begin
    forever begin
      do @(negedge clk); while (ps2_clk_line !== 1'b0);
      do @(negedge clk); while (!(ps2_clk_line === 1'b1 && ps2_dat_line === 1'b0));
      fe_count = 0;
      if (dev_mode != 2) begin
        dev_busy = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
          dev_clk  = 1'b0;
          fe_count = k;
          repeat (HALF / 2) @(negedge clk);
          if (k <= 10) cap[k-1] = ps2_dat_line;
          repeat (HALF / 2) @(negedge clk);
          dev_clk = 1'b1;
          if (k == 10 && dev_mode == 0) dev_dat = 1'b0;
          repeat (HALF) @(negedge clk);
        end
        dev_dat  = 1'b1;
        dev_busy = 1'b0;
      end
    end
  end

  // Monitor: every completion pulse consumes one expectation.
  always @(negedge clk) begin
    if (done || timeout) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: done=%0b timeout=%0b, none expected", done, timeout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done", 32'(done), 32'(!e.tmo));
        chk("timeout", 32'(timeout), 32'(e.tmo));
        chk("ack_error", 32'(ack_error), 32'(e.ack_err));
        if (!e.tmo) chk("frame_bits", 32'(cap), 32'(model_frame(e.data)));
      end
    end
  end

  task automatic wait_dev_idle();
    int n = 0;
    while (dev_busy && n < 3000) begin @(negedge clk); n++; end
    if (dev_busy) begin
      n_cmp++; n_err++;
      $display("FAIL dev_idle_wait: device still busy after %0d cycles", n);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input bit noise);
    int   n;
    exp_t e;
    dev_mode  = mode;
    e.data    = d;
    e.ack_err = (mode == 1);
    e.tmo     = (mode == 2);
    exp_q.push_back(e);
    @(negedge clk); tx_data = d; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; tx_data = 8'($urandom);
    chk("tx_ready_after_accept", 32'(tx_ready), 0);
    n = 0;
    while (cdl && !ddl && n < INH + 10) begin n++; @(negedge clk); end
    chk("inhibit_len", n, INH);
    chk("req_drives", 32'({cdl, ddl}), 32'h3);
    @(negedge clk);
    chk("send_entry_drives", 32'({cdl, ddl}), 32'h1);
    n = 0;
    while (!(done || timeout) && n < TMO + 100) begin
      @(negedge clk); n++;
      tx_valid = noise && fe_count >= 2 && fe_count <= 5;
      if (tx_valid) tx_data = 8'hAA;
    end
    tx_valid = 1'b0;
    if (!(done || timeout)) begin
      n_cmp++; n_err++;
      $display("FAIL completion_wait: no done/timeout within %0d cycles", n);
    end else begin
      chk("lines_released_at_end", 32'({cdl, ddl}), 0);
      chk("tx_ready_at_end", 32'(tx_ready), 1);
      if (mode == 2) chk("timeout_latency", n, TMO);
    end
    wait_dev_idle();
  endtask

  initial begin
    int bad;
    int n;
    @(negedge clk);
    chk("reset_state", 32'({tx_ready, cdl, ddl, done, ack_error, timeout}), 32'h20);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_ready !== 1'b1 || cdl || ddl || done || ack_error || timeout) bad++;
    end
    chk("idle_after_reset", bad, 0);

    send(8'hED, 0, 0);
    send(8'h01, 0, 0);
    send(8'hFF, 0, 0);
    send(8'hC3, 1, 0);
    send(8'h3C, 0, 1);
    send(8'h77, 2, 0);

    // Abort mid-frame: no completion is expected for this byte.
    dev_mode = 0;
    fe_count = 0;
    @(negedge clk); tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    n = 0;
    while (fe_count < 4 && n < 3000) begin @(negedge clk); n++; end
    chk("abort_reached_fe4", 32'(fe_count >= 4), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", 32'({tx_ready, cdl, ddl}), 32'h4);
    wait_dev_idle();
    repeat (50) @(negedge clk);

    send(8'hED, 0, 0);
    for (int i = 0; i < 6; i++) send(8'($urandom), int'($urandom_range(0, 1)), 0);

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
